// File: rtl/sdram_refresh_arbiter.sv
// SDRAM power-up init sequencer, periodic auto-refresh scheduler and command-path
// arbiter between Zorro III RAM accesses and refresh.
module sdram_refresh_arbiter #(
    parameter int INIT_WAIT_CYCLES = 2500,
    parameter int CMD_GAP          = 4,
    parameter int INIT_REFRESHES   = 8,
    parameter int REFRESH_INTERVAL = 195,
    parameter int MAX_PENDING      = 7
) (
    input  logic       CLK,
    input  logic       RESET_n,
    input  logic       access_req,
    input  logic       access_done,
    input  logic       refresh_done,
    output logic [1:0] cmd,
    output logic       cmd_valid,
    output logic       access_grant,
    output logic       ready,
    output logic [2:0] pending,
    output logic       overflow
);

    localparam int WAIT_MAX = (INIT_WAIT_CYCLES > CMD_GAP) ? INIT_WAIT_CYCLES : CMD_GAP;
    localparam int WAIT_W   = $clog2(WAIT_MAX + 1);
    localparam int REF_W    = $clog2(INIT_REFRESHES + 1);
    localparam int TMR_W    = $clog2(REFRESH_INTERVAL + 1);

    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(INIT_WAIT_CYCLES - 1);
    localparam logic [WAIT_W-1:0] GAP_LAST  = WAIT_W'(CMD_GAP - 1);
    localparam logic [WAIT_W-1:0] WAIT_ONE  = WAIT_W'(1'b1);
    localparam logic [REF_W-1:0]  REF_LAST  = REF_W'(INIT_REFRESHES - 1);
    localparam logic [REF_W-1:0]  REF_ONE   = REF_W'(1'b1);
    localparam logic [TMR_W-1:0]  TMR_LAST  = TMR_W'(REFRESH_INTERVAL - 1);
    localparam logic [TMR_W-1:0]  TMR_ONE   = TMR_W'(1'b1);
    localparam logic [2:0]        PEND_MAX  = 3'(MAX_PENDING);

    localparam logic [1:0] CMD_NOP  = 2'b00;
    localparam logic [1:0] CMD_PRE  = 2'b01;
    localparam logic [1:0] CMD_AREF = 2'b10;
    localparam logic [1:0] CMD_MRS  = 2'b11;

    typedef enum logic [2:0] {
        ST_INIT_WAIT = 3'd0,
        ST_INIT_PRE  = 3'd1,
        ST_INIT_REF  = 3'd2,
        ST_INIT_MODE = 3'd3,
        ST_IDLE      = 3'd4,
        ST_ACCESS    = 3'd5,
        ST_REFRESH   = 3'd6
    } state_t;

    state_t            state_r;
    state_t            state_next_s;
    logic [WAIT_W-1:0] wait_cnt_r;
    logic [WAIT_W-1:0] wait_cnt_next_s;
    logic [REF_W-1:0]  ref_cnt_r;
    logic [REF_W-1:0]  ref_cnt_next_s;
    logic [TMR_W-1:0]  tmr_r;
    logic [2:0]        pending_r;
    logic [2:0]        pending_next_s;
    logic              overflow_r;
    logic              overflow_next_s;
    logic              rearm_r;
    logic [1:0]        cmd_r;
    logic [1:0]        cmd_next_s;
    logic              cmd_valid_r;
    logic              cmd_valid_next_s;
    logic              grant_r;
    logic              grant_next_s;
    logic              ready_r;
    logic              ready_next_s;
    logic              done_ok_s;
    logic              tick_s;
    logic              retire_s;
    logic              grant_take_s;

    // A completion in the strobe cycle itself cannot belong to the command just issued.
    assign done_ok_s    = refresh_done & ~cmd_valid_r;
    assign tick_s       = ready_r & (tmr_r == TMR_LAST);
    assign retire_s     = (state_r == ST_REFRESH) & done_ok_s;
    assign grant_take_s = (state_r == ST_IDLE) & (state_next_s == ST_ACCESS);

    // State register and registered FSM outputs
    always_ff @(posedge CLK) begin
        if (!RESET_n) begin
            state_r     <= ST_INIT_WAIT;
            wait_cnt_r  <= {WAIT_W{1'b0}};
            ref_cnt_r   <= {REF_W{1'b0}};
            cmd_r       <= CMD_NOP;
            cmd_valid_r <= 1'b0;
            grant_r     <= 1'b0;
            ready_r     <= 1'b0;
        end else begin
            state_r     <= state_next_s;
            wait_cnt_r  <= wait_cnt_next_s;
            ref_cnt_r   <= ref_cnt_next_s;
            cmd_r       <= cmd_next_s;
            cmd_valid_r <= cmd_valid_next_s;
            grant_r     <= grant_next_s;
            ready_r     <= ready_next_s;
        end
    end

    // Next-state decode, including the IDLE arbitration priority
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_INIT_WAIT: begin
                if (wait_cnt_r == WAIT_LAST) state_next_s = ST_INIT_PRE;
                else                         state_next_s = state_r;
            end
            ST_INIT_PRE: begin
                if (wait_cnt_r == GAP_LAST) state_next_s = ST_INIT_REF;
                else                        state_next_s = state_r;
            end
            ST_INIT_REF: begin
                if (done_ok_s && (ref_cnt_r == REF_LAST)) state_next_s = ST_INIT_MODE;
                else                                       state_next_s = state_r;
            end
            ST_INIT_MODE: begin
                if (wait_cnt_r == GAP_LAST) state_next_s = ST_IDLE;
                else                        state_next_s = state_r;
            end
            ST_IDLE: begin
                if (pending_r == PEND_MAX)         state_next_s = ST_REFRESH;
                else if (access_req && rearm_r)    state_next_s = ST_ACCESS;
                else if (pending_r != 3'd0)        state_next_s = ST_REFRESH;
                else                               state_next_s = ST_IDLE;
            end
            ST_ACCESS: begin
                if (access_done) state_next_s = ST_IDLE;
                else             state_next_s = state_r;
            end
            ST_REFRESH: begin
                if (done_ok_s) state_next_s = ST_IDLE;
                else           state_next_s = state_r;
            end
            default: state_next_s = ST_INIT_WAIT;
        endcase
    end

    // Output and sequencing-counter next values; commands strobe on state entry
    always_comb begin
        cmd_next_s       = cmd_r;
        cmd_valid_next_s = 1'b0;
        grant_next_s     = grant_r;
        ready_next_s     = ready_r;
        wait_cnt_next_s  = wait_cnt_r;
        ref_cnt_next_s   = ref_cnt_r;
        case (state_r)
            ST_INIT_WAIT: begin
                if (state_next_s == ST_INIT_PRE) begin
                    wait_cnt_next_s  = {WAIT_W{1'b0}};
                    cmd_next_s       = CMD_PRE;
                    cmd_valid_next_s = 1'b1;
                end else begin
                    wait_cnt_next_s  = wait_cnt_r + WAIT_ONE;
                end
            end
            ST_INIT_PRE: begin
                if (state_next_s == ST_INIT_REF) begin
                    wait_cnt_next_s  = {WAIT_W{1'b0}};
                    ref_cnt_next_s   = {REF_W{1'b0}};
                    cmd_next_s       = CMD_AREF;
                    cmd_valid_next_s = 1'b1;
                end else begin
                    wait_cnt_next_s  = wait_cnt_r + WAIT_ONE;
                end
            end
            ST_INIT_REF: begin
                if (state_next_s == ST_INIT_MODE) begin
                    wait_cnt_next_s  = {WAIT_W{1'b0}};
                    cmd_next_s       = CMD_MRS;
                    cmd_valid_next_s = 1'b1;
                end else if (done_ok_s) begin
                    ref_cnt_next_s   = ref_cnt_r + REF_ONE;
                    cmd_next_s       = CMD_AREF;
                    cmd_valid_next_s = 1'b1;
                end else begin
                    ref_cnt_next_s   = ref_cnt_r;
                end
            end
            ST_INIT_MODE: begin
                if (state_next_s == ST_IDLE) begin
                    wait_cnt_next_s = {WAIT_W{1'b0}};
                    ready_next_s    = 1'b1;
                end else begin
                    wait_cnt_next_s = wait_cnt_r + WAIT_ONE;
                end
            end
            ST_IDLE: begin
                if (state_next_s == ST_REFRESH) begin
                    cmd_next_s       = CMD_AREF;
                    cmd_valid_next_s = 1'b1;
                end else if (state_next_s == ST_ACCESS) begin
                    grant_next_s     = 1'b1;
                end else begin
                    grant_next_s     = 1'b0;
                end
            end
            ST_ACCESS: begin
                if (state_next_s == ST_IDLE) grant_next_s = 1'b0;
                else                         grant_next_s = 1'b1;
            end
            ST_REFRESH: cmd_valid_next_s = 1'b0;
            default: begin
                cmd_valid_next_s = 1'b0;
                grant_next_s     = 1'b0;
            end
        endcase
    end

    // Pending-refresh bookkeeping: a tick and a retire in the same clock cancel out
    always_comb begin
        pending_next_s  = pending_r;
        overflow_next_s = overflow_r;
        if (tick_s && !retire_s) begin
            if (pending_r == PEND_MAX) overflow_next_s = 1'b1;
            else                       pending_next_s  = pending_r + 3'd1;
        end else if (retire_s && !tick_s) begin
            pending_next_s = pending_r - 3'd1;
        end else begin
            pending_next_s = pending_r;
        end
    end

    // Refresh interval timer, pending counter, sticky overflow and per-Z3-cycle rearm
    always_ff @(posedge CLK) begin
        if (!RESET_n) begin
            tmr_r      <= {TMR_W{1'b0}};
            pending_r  <= 3'd0;
            overflow_r <= 1'b0;
            rearm_r    <= 1'b1;
        end else begin
            if (!ready_r)              tmr_r <= {TMR_W{1'b0}};
            else if (tmr_r == TMR_LAST) tmr_r <= {TMR_W{1'b0}};
            else                       tmr_r <= tmr_r + TMR_ONE;
            pending_r  <= pending_next_s;
            overflow_r <= overflow_next_s;
            if (grant_take_s)     rearm_r <= 1'b0;
            else if (!access_req) rearm_r <= 1'b1;
            else                  rearm_r <= rearm_r;
        end
    end

    assign cmd          = cmd_r;
    assign cmd_valid    = cmd_valid_r;
    assign access_grant = grant_r;
    assign ready        = ready_r;
    assign pending      = pending_r;
    assign overflow     = overflow_r;

endmodule

// File: tb/tb_sdram_refresh_arbiter.sv
// Randomized and directed bench for sdram_refresh_arbiter against a time-based
// behavioural model (absolute deadlines, arithmetic refresh ticks).
module tb_sdram_refresh_arbiter;

    localparam int IW   = 20;
    localparam int CG   = 4;
    localparam int IR   = 8;
    localparam int RI   = 10;
    localparam int MAXP = 7;

    logic       CLK = 1'b0;
    logic       RESET_n = 1'b0;
    logic       access_req = 1'b0;
    logic       access_done = 1'b0;
    logic       refresh_done = 1'b0;
    logic [1:0] cmd;
    logic       cmd_valid;
    logic       access_grant;
    logic       ready;
    logic [2:0] pending;
    logic       overflow;

    always #5 CLK = ~CLK;

    sdram_refresh_arbiter #(
        .INIT_WAIT_CYCLES(IW),
        .CMD_GAP(CG),
        .INIT_REFRESHES(IR),
        .REFRESH_INTERVAL(RI),
        .MAX_PENDING(MAXP)
    ) dut (
        .CLK(CLK),
        .RESET_n(RESET_n),
        .access_req(access_req),
        .access_done(access_done),
        .refresh_done(refresh_done),
        .cmd(cmd),
        .cmd_valid(cmd_valid),
        .access_grant(access_grant),
        .ready(ready),
        .pending(pending),
        .overflow(overflow)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Reference model: mode 0 init, 1 idle, 2 access, 3 refresh
    int         cyc, init_step, init_due, init_refs, ready_at;
    int         m_mode, m_pend;
    bit         m_ovf, m_ready, m_grant, m_valid, m_rearm;
    logic [1:0] m_cmd;

    int ref_strobes = 0;
    int first_pre   = -1;
    bit grant_seen  = 1'b0;

    task automatic issue(input logic [1:0] c);
        m_cmd   = c;
        m_valid = 1'b1;
    endtask

    task automatic model_step(input bit rst, input bit req, input bit adone, input bit rdone);
        bit was_ready, prev_valid, tick, retire, granted, done_ok;
        if (!rst) begin
            cyc = 0; init_step = 0; init_due = 0; init_refs = 0; ready_at = 0;
            m_mode = 0; m_pend = 0; m_ovf = 1'b0; m_ready = 1'b0; m_grant = 1'b0;
            m_valid = 1'b0; m_rearm = 1'b1; m_cmd = 2'b00;
        end else begin
            was_ready  = m_ready;
            prev_valid = m_valid;
            m_valid    = 1'b0;
            retire     = 1'b0;
            granted    = 1'b0;
            cyc++;
            done_ok = rdone && !prev_valid;
            tick    = was_ready && (((cyc - ready_at) % RI) == 0);
            case (m_mode)
                0: begin
                    if (init_step == 0) begin
                        if (cyc == IW) begin issue(2'b01); init_due = cyc + CG; init_step = 1; end
                    end else if (init_step == 1) begin
                        if (cyc == init_due) begin issue(2'b10); init_refs = 1; init_step = 2; end
                    end else if (init_step == 2) begin
                        if (done_ok) begin
                            if (init_refs == IR) begin issue(2'b11); init_due = cyc + CG; init_step = 3; end
                            else begin issue(2'b10); init_refs++; end
                        end
                    end else if (cyc == init_due) begin
                        m_mode = 1; m_ready = 1'b1; ready_at = cyc;
                    end
                end
                1: begin
                    if (m_pend == MAXP) begin m_mode = 3; issue(2'b10); end
                    else if (req && m_rearm) begin m_mode = 2; m_grant = 1'b1; granted = 1'b1; end
                    else if (m_pend != 0) begin m_mode = 3; issue(2'b10); end
                end
                2: if (adone) begin m_mode = 1; m_grant = 1'b0; end
                3: if (done_ok) begin m_mode = 1; retire = 1'b1; end
                default: m_mode = 0;
            endcase
            if (tick && !retire) begin
                if (m_pend == MAXP) m_ovf = 1'b1;
                else m_pend++;
            end else if (retire && !tick) begin
                m_pend--;
            end
            if (granted) m_rearm = 1'b0;
            else if (!req) m_rearm = 1'b1;
        end
    endtask

    function automatic bit rdone_auto();
        return ((m_mode == 3) || (m_mode == 0 && init_step == 2)) && !m_valid;
    endfunction

    task automatic step(input bit rst, input bit req, input bit adone, input bit rdone);
        RESET_n = rst; access_req = req; access_done = adone; refresh_done = rdone;
        @(posedge CLK);
        model_step(rst, req, adone, rdone);
        #1;
        check_eq("outputs", {cmd, cmd_valid, access_grant, ready, pending, overflow},
                 {m_cmd, m_valid, m_grant, m_ready, m_pend[2:0], m_ovf});
        if (cmd_valid && cmd == 2'b10) ref_strobes++;
        if (cmd_valid && cmd == 2'b01 && first_pre < 0) first_pre = cyc;
        if (access_grant) grant_seen = 1'b1;
    endtask

    task automatic run_random(input int n);
        int  z3_left = 0;
        bit  req_v   = 1'b0;
        bit  ad, rd;
        for (int i = 0; i < n; i++) begin
            if (z3_left == 0) begin
                req_v   = ~req_v;
                z3_left = req_v ? int'($urandom_range(2, 14)) : int'($urandom_range(1, 6));
            end
            z3_left--;
            ad = m_grant ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 15) == 0);
            rd = rdone_auto() ? ($urandom_range(0, 2) == 0) : (!m_valid && $urandom_range(0, 15) == 0);
            step(1'b1, req_v, ad, rd);
        end
    endtask

    initial begin
        // Reset and power-up init with idle inputs
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, 1'b0);
        check_eq("reset_state", {cmd, cmd_valid, access_grant, ready, pending, overflow}, 32'd0);
        ref_strobes = 0;
        for (int i = 0; i < 400 && !m_ready; i++) step(1'b1, 1'b0, 1'b0, rdone_auto());
        check_eq("init_pre_cycle", first_pre, IW);
        check_eq("init_refreshes", ref_strobes, IR);
        check_eq("ready_after_init", ready, 1'b1);

        run_random(600);

        // Quiesce, then a long access lets pending saturate
        for (int i = 0; i < 60 && !(m_mode == 1 && m_pend == 0); i++)
            step(1'b1, 1'b0, m_grant, rdone_auto());
        for (int i = 0; i < 20 && !m_grant; i++) step(1'b1, 1'b1, 1'b0, rdone_auto());
        check_eq("sat_grant", access_grant, 1'b1);
        for (int i = 0; i < 85; i++) step(1'b1, 1'b1, 1'b0, 1'b0);
        check_eq("sat_pending", pending, 3'd7);
        check_eq("sat_overflow", overflow, 1'b1);
        step(1'b1, 1'b1, 1'b1, 1'b0);
        ref_strobes = 0;
        grant_seen  = 1'b0;
        for (int i = 0; i < 80 && !(m_mode == 1 && m_pend == 0); i++)
            step(1'b1, 1'b1, 1'b0, rdone_auto());
        check_eq("drain_refreshes_ge7", ref_strobes >= 7, 1'b1);
        check_eq("no_grant_during_drain", grant_seen, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 20 && !m_grant; i++) step(1'b1, 1'b1, 1'b0, rdone_auto());
        check_eq("regrant_after_drain", access_grant, 1'b1);

        // Urgent refresh beats a rearmed access request in IDLE
        for (int i = 0; i < 85; i++) step(1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        check_eq("urgent_refresh", {cmd_valid, cmd, access_grant}, 4'b1100);
        for (int i = 0; i < 40 && !m_grant; i++) step(1'b1, 1'b1, 1'b0, rdone_auto());
        check_eq("grant_after_urgent", access_grant, 1'b1);

        // Reset in the middle of an access replays init
        step(1'b0, 1'b1, 1'b0, 1'b0);
        check_eq("reset_in_access", {access_grant, ready, cmd_valid, pending}, 6'd0);
        ref_strobes = 0;
        for (int i = 0; i < 400 && !m_ready; i++) step(1'b1, 1'b0, 1'b0, rdone_auto());
        check_eq("reinit_refreshes", ref_strobes, IR);
        check_eq("reinit_ready", ready, 1'b1);
        for (int i = 0; i < 5 && !m_grant; i++) step(1'b1, 1'b1, 1'b0, rdone_auto());
        check_eq("grant_after_reinit", access_grant, 1'b1);

        run_random(300);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
